pmu_wakeup_sequencer: RTL

Parametrised successor to the single-purpose wakeup counter. Sequences N power domains down and back up in fixed index order with per-domain acknowledge and timeout. Retains a programmable subset of domains during sleep, and wakes on a prescaled timer or an external event. Sits in the always-on domain of pulp_soc, driving the per-domain PowerGateFSM instances.

---
 rtl/pmu_wakeup_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/pmu_wakeup_sequencer.sv
// Always-on power sequencer: ordered per-domain power-down, timer/external sleep,
// ordered power-up, each step bounded by an acknowledge timeout.
module pmu_wakeup_sequencer #(
  parameter int N_DOMAINS   = 6,
  parameter int CNT_WIDTH   = 32,
  parameter int PRESCALE    = 32,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 wen_i,
  input  logic                 reg_pmu_en_i,
  input  logic [CNT_WIDTH-1:0] reg_sleep_time_i,
  input  logic [N_DOMAINS-1:0] reg_retain_mask_i,
  input  logic                 ext_wakeup_i,
  input  logic [N_DOMAINS-1:0] pwr_ack_i,
  output logic [N_DOMAINS-1:0] pwr_req_o,
  output logic                 sleeping_o,
  output logic                 rstn_pg_o,
  output logic [1:0]           wakeup_cause_o,
  output logic                 timeout_err_o,
  output logic [CNT_WIDTH-1:0] elapsed_o,
  output logic [CNT_WIDTH-1:0] reg_sleep_time_o,
  output logic [N_DOMAINS-1:0] reg_retain_mask_o
);
  localparam int IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
  localparam int PRE_W = $clog2(PRESCALE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DOMAINS - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(ACK_TIMEOUT);
  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(PRESCALE - 1);

  typedef enum logic [1:0] {ST_ACTIVE, ST_PD_SEQ, ST_SLEEP, ST_PU_SEQ} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [PRE_W-1:0]     presc_q, presc_d;
  logic [CNT_WIDTH-1:0] elapsed_q, elapsed_d;
  logic [CNT_WIDTH-1:0] sleep_time_q, sleep_time_d;
  logic [N_DOMAINS-1:0] retain_q, retain_d;
  logic [1:0]           cause_q, cause_d;
  logic                 tmo_err_q, tmo_err_d;
  logic                 pend_ext_q, pend_ext_d;
  logic                 ack_ok, step, wake_timer, wake_ext;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path infers a latch.
    state_d      = state_q;
    idx_d        = idx_q;
    tmo_d        = tmo_q;
    presc_d      = presc_q;
    elapsed_d    = elapsed_q;
    sleep_time_d = sleep_time_q;
    retain_d     = retain_q;
    cause_d      = cause_q;
    tmo_err_d    = tmo_err_q;
    pend_ext_d   = pend_ext_q;
    ack_ok       = 1'b0;
    step         = 1'b0;
    wake_timer   = 1'b0;
    wake_ext     = 1'b0;
    case (state_q)
      ST_ACTIVE: begin
        if (wen_i) begin
          sleep_time_d = reg_sleep_time_i;
          retain_d     = reg_retain_mask_i;
          tmo_err_d    = 1'b0;
          if (reg_pmu_en_i) begin
            state_d    = ST_PD_SEQ;
            idx_d      = LAST_IDX;
            tmo_d      = '0;
            cause_d    = 2'd0;
            elapsed_d  = '0;
            pend_ext_d = 1'b0;
          end
        end
      end
      ST_PD_SEQ, ST_PU_SEQ: begin
        // Ack is tested before the limit, so an ack landing on the limit cycle is a success.
        ack_ok = (state_q == ST_PD_SEQ) ? !pwr_ack_i[idx_q] : pwr_ack_i[idx_q];
        step   = retain_q[idx_q] || ack_ok || (tmo_q == TMO_MAX);
        if (state_q == ST_PD_SEQ && ext_wakeup_i) pend_ext_d = 1'b1;
        if (!retain_q[idx_q] && !ack_ok && tmo_q == TMO_MAX) tmo_err_d = 1'b1;
        if (!step) begin
          tmo_d = tmo_q + TMO_W'(1);
        end else begin
          tmo_d = '0;
          if (state_q == ST_PD_SEQ) begin
            if (idx_q == '0) begin
              state_d = ST_SLEEP;
              presc_d = '0;
            end else begin
              idx_d = idx_q - IDX_W'(1);
            end
          end else begin
            if (idx_q == LAST_IDX) state_d = ST_ACTIVE;
            else                   idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      ST_SLEEP: begin
        wake_timer = (elapsed_q >= sleep_time_q);
        wake_ext   = ext_wakeup_i | pend_ext_q;
        if (wake_timer || wake_ext) begin
          cause_d    = {wake_ext, wake_timer};
          state_d    = ST_PU_SEQ;
          idx_d      = '0;
          tmo_d      = '0;
          pend_ext_d = 1'b0;
        end else if (presc_q == PRE_MAX) begin
          presc_d = '0;
          if (elapsed_q != '1) elapsed_d = elapsed_q + CNT_WIDTH'(1);
        end else begin
          presc_d = presc_q + PRE_W'(1);
        end
      end
      default: state_d = ST_ACTIVE;
    endcase
  end

  // Domains below the current index are untouched on the way down, already up on the way back.
  always_comb begin
    pwr_req_o = '1;
    for (int i = 0; i < N_DOMAINS; i++) begin
      case (state_q)
        ST_PD_SEQ: pwr_req_o[i] = retain_q[i] | (IDX_W'(i) < idx_q);
        ST_SLEEP:  pwr_req_o[i] = retain_q[i];
        ST_PU_SEQ: pwr_req_o[i] = retain_q[i] | (IDX_W'(i) <= idx_q);
        default:   pwr_req_o[i] = 1'b1;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= ST_ACTIVE;
      idx_q        <= '0;
      tmo_q        <= '0;
      presc_q      <= '0;
      elapsed_q    <= '0;
      sleep_time_q <= '0;
      retain_q     <= '0;
      cause_q      <= 2'd0;
      tmo_err_q    <= 1'b0;
      pend_ext_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tmo_q        <= tmo_d;
      presc_q      <= presc_d;
      elapsed_q    <= elapsed_d;
      sleep_time_q <= sleep_time_d;
      retain_q     <= retain_d;
      cause_q      <= cause_d;
      tmo_err_q    <= tmo_err_d;
      pend_ext_q   <= pend_ext_d;
    end
  end

  assign sleeping_o        = (state_q != ST_ACTIVE);
  assign rstn_pg_o         = !sleeping_o;
  assign wakeup_cause_o    = cause_q;
  assign timeout_err_o     = tmo_err_q;
  assign elapsed_o         = elapsed_q;
  assign reg_sleep_time_o  = sleep_time_q;
  assign reg_retain_mask_o = retain_q;

endmodule
